// File: rtl/uart_tx_fifo_drain.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_drain : pops bytes from the tx fifo and serialises UART frames.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    LATCH  = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    rd_en_d  = 1'b0;
    done_d   = 1'b0;

    // Baud counter only runs while a bit is on the line.
    if (state_q == START || state_q == DATA || state_q == PARITY || state_q == STOP) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          rd_en_d = 1'b1;
          state_d = REQ;
        end
      end
      REQ: state_d = LATCH;
      LATCH: begin
        shift_d  = fifo_data;
        parity_d = (^fifo_data) ^ (PARITY_ODD != 0);
        tx_d     = 1'b0;
        cnt_d    = '0;
        state_d  = START;
      end
      START: begin
        if (bit_end) begin
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            // Shift right so the next bit always sits at index 1 of the old value.
            idx_d   = idx_q + IDX_W'(1);
            tx_d    = shift_q[1];
            shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          idx_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      rd_en_q  <= rd_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo_drain.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo_drain : directed bench over four frame-format configurations.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_fifo_drain;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: 8N1, 1: even parity, 2: odd parity, 3: two stop bits.
  logic [3:0] tx_w, rd_w, busy_w, done_w, empty_w;
  logic [7:0] fdata [4];
  logic [7:0] mem [4][16];
  int head [4] = '{default: 0};
  int tail [4] = '{default: 0};
  int pops [4] = '{default: 0};
  int bad_pops [4] = '{default: 0};

  logic tx_log   [4][128];
  logic rd_log   [4][128];
  logic busy_log [4][128];
  logic done_log [4][128];

  int checks = 0;
  int passed = 0;

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .fifo_empty(empty_w[0]), .fifo_data(fdata[0]),
    .fifo_rd_en(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst), .fifo_empty(empty_w[1]), .fifo_data(fdata[1]),
    .fifo_rd_en(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .fifo_empty(empty_w[2]), .fifo_data(fdata[2]),
    .fifo_rd_en(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst(rst), .fifo_empty(empty_w[3]), .fifo_data(fdata[3]),
    .fifo_rd_en(rd_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]));

  // Fifo models: registered data_out, valid the cycle after the rd_en cycle.
  always_comb begin
    for (int i = 0; i < 4; i++) empty_w[i] = (head[i] == tail[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rd_w[i]) begin
        if (head[i] != tail[i]) begin
          fdata[i] <= mem[i][head[i] % 16];
          head[i]  <= head[i] + 1;
          pops[i]  <= pops[i] + 1;
        end else begin
          bad_pops[i] <= bad_pops[i] + 1;
        end
      end
    end
  end

  task automatic push(input int inst, input logic [7:0] b);
    mem[inst][tail[inst] % 16] = b;
    tail[inst] = tail[inst] + 1;
  endtask

  task automatic record(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        tx_log[i][k]   = tx_w[i];
        rd_log[i][k]   = rd_w[i];
        busy_log[i][k] = busy_w[i];
        done_log[i][k] = done_w[i];
      end
    end
  endtask

  function automatic int cnt1(input int sel, input int inst, input int from, input int to);
    int c = 0;
    for (int k = from; k <= to; k++) begin
      case (sel)
        0: c += int'(tx_log[inst][k]);
        1: c += int'(rd_log[inst][k]);
        2: c += int'(busy_log[inst][k]);
        default: c += int'(done_log[inst][k]);
      endcase
    end
    return c;
  endfunction

  // Expected line level at frame cycle k (4 clocks per bit).
  function automatic logic exp_bit(input logic [7:0] b, input int par_en, input int par_odd, input int k);
    int slot = k / 4;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (par_en != 0 && slot == 9) return (^b) ^ (par_odd != 0);
    return 1'b1;
  endfunction

  task automatic frame_bad(input int inst, input logic [7:0] b, input int par_en, input int par_odd,
                           input int stops, input int start, output int bad);
    int len = (1 + 8 + par_en + stops) * 4;
    bad = 0;
    for (int k = 0; k < len; k++)
      if (tx_log[inst][start+k] !== exp_bit(b, par_en, par_odd, k)) bad++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx_w !== 4'hF) $display("FAIL reset_tx: got %b want 1111", tx_w); else passed++;
    checks++; if (rd_w !== 4'h0) $display("FAIL reset_rd_en: got %b want 0000", rd_w); else passed++;
    checks++; if (busy_w !== 4'h0) $display("FAIL reset_busy: got %b want 0000", busy_w); else passed++;
    checks++; if (done_w !== 4'h0) $display("FAIL reset_tx_done: got %b want 0000", done_w); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_idle_empty;
    int n_tx, n_rd, n_busy;
    n_tx = 0; n_rd = 0; n_busy = 0;
    for (int blk = 0; blk < 2; blk++) begin
      record(100);
      n_tx   += cnt1(0, 0, 0, 99);
      n_rd   += cnt1(1, 0, 0, 99);
      n_busy += cnt1(2, 0, 0, 99);
    end
    checks++; if (n_tx !== 200) $display("FAIL idle_tx_high: got %0d cycles high want 200", n_tx); else passed++;
    checks++; if (n_rd !== 0) $display("FAIL idle_rd_en: got %0d pulses want 0", n_rd); else passed++;
    checks++; if (n_busy !== 0) $display("FAIL idle_busy: got %0d busy cycles want 0", n_busy); else passed++;
  endtask

  task automatic test_8n1;
    int bad;
    push(0, 8'hA5);
    record(60);
    frame_bad(0, 8'hA5, 0, 0, 1, 2, bad);
    checks++; if (rd_log[0][0] !== 1'b1 || rd_log[0][1] !== 1'b0)
      $display("FAIL a5_rd_latency: got %b%b want 10", rd_log[0][0], rd_log[0][1]); else passed++;
    checks++; if (cnt1(1, 0, 0, 59) !== 1) $display("FAIL a5_rd_pulses: got %0d want 1", cnt1(1, 0, 0, 59)); else passed++;
    checks++; if (tx_log[0][0] !== 1'b1 || tx_log[0][1] !== 1'b1 || tx_log[0][2] !== 1'b0)
      $display("FAIL a5_tx_fall: got %b%b%b want 110", tx_log[0][0], tx_log[0][1], tx_log[0][2]); else passed++;
    checks++; if (bad !== 0) $display("FAIL a5_frame: got %0d wrong cycles want 0", bad); else passed++;
    checks++; if (done_log[0][42] !== 1'b1 || cnt1(3, 0, 0, 59) !== 1)
      $display("FAIL a5_tx_done: got %b at 42, %0d pulses want 1 and 1", done_log[0][42], cnt1(3, 0, 0, 59)); else passed++;
    checks++; if (cnt1(2, 0, 0, 59) !== 42 || busy_log[0][42] !== 1'b0)
      $display("FAIL a5_busy: got %0d cycles, %b at 42 want 42 and 0", cnt1(2, 0, 0, 59), busy_log[0][42]); else passed++;
  endtask

  task automatic test_parity_stop2;
    int bad_e, bad_o, bad_s;
    push(1, 8'h07);
    push(2, 8'h07);
    push(3, 8'h55);
    record(60);
    frame_bad(1, 8'h07, 1, 0, 1, 2, bad_e);
    frame_bad(2, 8'h07, 1, 1, 1, 2, bad_o);
    frame_bad(3, 8'h55, 0, 0, 2, 2, bad_s);
    checks++; if (cnt1(0, 1, 38, 41) !== 4) $display("FAIL even_parity_bit: got %0d high cycles want 4", cnt1(0, 1, 38, 41)); else passed++;
    checks++; if (bad_e !== 0 || done_log[1][46] !== 1'b1)
      $display("FAIL even_frame: got %0d wrong, done %b want 0 and 1", bad_e, done_log[1][46]); else passed++;
    checks++; if (cnt1(0, 2, 38, 41) !== 0) $display("FAIL odd_parity_bit: got %0d high cycles want 0", cnt1(0, 2, 38, 41)); else passed++;
    checks++; if (bad_o !== 0 || done_log[2][46] !== 1'b1)
      $display("FAIL odd_frame: got %0d wrong, done %b want 0 and 1", bad_o, done_log[2][46]); else passed++;
    checks++; if (cnt1(0, 3, 38, 45) !== 8 || tx_log[3][37] !== 1'b0)
      $display("FAIL stop2_len: got %0d stop cycles, last data %b want 8 and 0", cnt1(0, 3, 38, 45), tx_log[3][37]); else passed++;
    checks++; if (bad_s !== 0 || done_log[3][45] !== 1'b0 || done_log[3][46] !== 1'b1 || cnt1(3, 3, 0, 59) !== 1)
      $display("FAIL stop2_done: got %0d wrong, done45=%b done46=%b want 0,0,1", bad_s, done_log[3][45], done_log[3][46]); else passed++;
  endtask

  task automatic test_back_to_back;
    int bad1, bad2, p0;
    p0 = pops[0];
    push(0, 8'h00);
    push(0, 8'hFF);
    record(100);
    frame_bad(0, 8'h00, 0, 0, 1, 2, bad1);
    frame_bad(0, 8'hFF, 0, 0, 1, 45, bad2);
    checks++; if (cnt1(1, 0, 0, 99) !== 2 || cnt1(3, 0, 0, 99) !== 2)
      $display("FAIL b2b_pulses: got rd=%0d done=%0d want 2 and 2", cnt1(1, 0, 0, 99), cnt1(3, 0, 0, 99)); else passed++;
    checks++; if (bad1 !== 0 || bad2 !== 0) $display("FAIL b2b_frames: got %0d/%0d wrong want 0/0", bad1, bad2); else passed++;
    checks++; if (cnt1(0, 0, 42, 44) !== 3 || tx_log[0][45] !== 1'b0 || done_log[0][42] !== 1'b1)
      $display("FAIL b2b_gap: got %0d high gap cycles, start %b want 3 and 0", cnt1(0, 0, 42, 44), tx_log[0][45]); else passed++;
    checks++; if (done_log[0][85] !== 1'b1) $display("FAIL b2b_done2: got %b want 1", done_log[0][85]); else passed++;
    checks++; if (empty_w[0] !== 1'b1 || pops[0] - p0 !== 2)
      $display("FAIL b2b_empty: got empty=%b pops=%0d want 1 and 2", empty_w[0], pops[0] - p0); else passed++;
  endtask

  task automatic test_reset_mid_frame;
    int bad;
    push(0, 8'h3C);
    push(0, 8'h81);
    record(19);
    checks++; if (tx_log[0][18] !== 1'b1 || cnt1(3, 0, 0, 18) !== 0)
      $display("FAIL rst_mid_bit3: got tx=%b done=%0d want 1 and 0", tx_log[0][18], cnt1(3, 0, 0, 18)); else passed++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || rd_w[0] !== 1'b0)
      $display("FAIL rst_mid_state: got tx=%b busy=%b done=%b rd=%b want 1000", tx_w[0], busy_w[0], done_w[0], rd_w[0]); else passed++;
    rst = 1'b0;
    record(60);
    frame_bad(0, 8'h81, 0, 0, 1, 2, bad);
    checks++; if (rd_log[0][0] !== 1'b1 || cnt1(1, 0, 0, 59) !== 1)
      $display("FAIL rst_mid_repop: got rd0=%b pulses=%0d want 1 and 1", rd_log[0][0], cnt1(1, 0, 0, 59)); else passed++;
    checks++; if (bad !== 0 || done_log[0][42] !== 1'b1 || cnt1(3, 0, 0, 59) !== 1)
      $display("FAIL rst_mid_0x81: got %0d wrong, done=%b want 0 and 1", bad, done_log[0][42]); else passed++;
  endtask

  initial begin
    test_reset();
    test_idle_empty();
    test_8n1();
    test_parity_stop2();
    test_back_to_back();
    test_reset_mid_frame();
    checks++;
    if ((bad_pops[0] + bad_pops[1] + bad_pops[2] + bad_pops[3]) !== 0)
      $display("FAIL rd_en_when_empty: got %0d pops of empty fifo want 0",
               bad_pops[0] + bad_pops[1] + bad_pops[2] + bad_pops[3]);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
